// File: rtl/lin_pkg.sv
// rtl/lin_pkg.sv - shared state encoding and record constants for the linearizer batch driver
package lin_pkg;

  localparam int LIN_P     = 32;
  localparam int LIN_REC_W = LIN_P + 2;

  // Record written when the linearizer never answers: both flags plus an all-ones result.
  localparam logic [LIN_REC_W-1:0] LIN_TIMEOUT_REC = {2'b11, {LIN_P{1'b1}}};

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_CLEAR,
    ST_GO,
    ST_WAIT,
    ST_STORE,
    ST_NEXT,
    ST_DONE
  } lin_state_e;

endpackage

// File: rtl/lin_wdog.sv
// rtl/lin_wdog.sv - per-sample watchdog: cleared before each start pulse, counts WAIT cycles
module lin_wdog #(
  parameter int TIMEOUT = 2500
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/lin_batch_driver.sv
// rtl/lin_batch_driver.sv - walks the sample ROM through the linearizer handshake and
// stores {O_F,U_F,RESULT} per sample into the result RAM
module lin_batch_driver
  import lin_pkg::*;
#(
  parameter int P         = 32,
  parameter int AW        = 10,
  parameter int N_SAMPLES = 1024,
  parameter int TIMEOUT   = 2500
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic          TIMEOUT_ERR,
  output logic          RD_EN,
  output logic [AW-1:0] RD_ADDR,
  input  logic [P-1:0]  RD_DATA,
  output logic [P-1:0]  T,
  output logic          RST_FSM_LN,
  output logic          BEGIN_FSM_LN,
  input  logic          ACK_LN,
  input  logic          O_F,
  input  logic          U_F,
  input  logic [P-1:0]  RESULT,
  output logic          WR_EN,
  output logic [AW-1:0] WR_ADDR,
  output logic [P+1:0]  WR_DATA
);

  localparam logic [P+1:0] TIMEOUT_REC = {2'b11, {P{1'b1}}};

  lin_state_e    r_state;
  lin_state_e    w_next;
  logic [AW-1:0] r_idx;
  logic [P-1:0]  r_t;
  logic [P+1:0]  r_wr_data;
  logic          r_terr;
  logic [AW:0]   w_idx_inc;
  logic          w_last;
  logic          w_expired;
  logic          w_busy;
  logic          w_done;
  logic          w_rd_en;
  logic          w_rst_ln;
  logic          w_begin;
  logic          w_wr_en;

  // One extra bit so a full 2**AW batch still terminates instead of wrapping to 0.
  assign w_idx_inc = {1'b0, r_idx} + {{AW{1'b0}}, 1'b1};
  assign w_last    = (w_idx_inc == (AW+1)'(N_SAMPLES));

  lin_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .i_clk  (CLK),
    .i_rst_n(RST_N),
    .i_clr  (w_begin),
    .i_en   (r_state == ST_WAIT),
    .expired(w_expired)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b1;
    w_done   = 1'b0;
    w_rd_en  = 1'b0;
    w_rst_ln = 1'b0;
    w_begin  = 1'b0;
    w_wr_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy   = 1'b0;
        w_rst_ln = 1'b1;
        if (START) begin
          w_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_rd_en = 1'b1;
        w_next  = ST_LOAD;
      end
      ST_LOAD: begin
        w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_rst_ln = 1'b1;
        w_next   = ST_GO;
      end
      ST_GO: begin
        w_begin = 1'b1;
        w_next  = ST_WAIT;
      end
      ST_WAIT: begin
        if (ACK_LN || w_expired) begin
          w_next = ST_STORE;
        end
      end
      ST_STORE: begin
        w_wr_en = 1'b1;
        w_next  = ST_NEXT;
      end
      ST_NEXT: begin
        w_next = w_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  // ACK is checked before the watchdog so a reply on the final WAIT cycle is kept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx     <= '0;
      r_t       <= '0;
      r_wr_data <= '0;
      r_terr    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_idx  <= '0;
            r_terr <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_t <= RD_DATA;
        end
        ST_WAIT: begin
          if (ACK_LN) begin
            r_wr_data <= {O_F, U_F, RESULT};
          end else if (w_expired) begin
            r_wr_data <= TIMEOUT_REC;
            r_terr    <= 1'b1;
          end
        end
        ST_NEXT: begin
          if (!w_last) begin
            r_idx <= w_idx_inc[AW-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign BUSY         = w_busy;
  assign DONE         = w_done;
  assign TIMEOUT_ERR  = r_terr;
  assign RD_EN        = w_rd_en;
  assign RD_ADDR      = r_idx;
  assign T            = r_t;
  assign RST_FSM_LN   = w_rst_ln;
  assign BEGIN_FSM_LN = w_begin;
  assign WR_EN        = w_wr_en;
  assign WR_ADDR      = r_idx;
  assign WR_DATA      = r_wr_data;

endmodule

// File: tb/tb_lin_batch_driver.sv
// tb/tb_lin_batch_driver.sv - self-checking bench for lin_batch_driver
module tb_lin_batch_driver;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  int errors;
  int checks;

  logic start_v [3];
  logic busy_v  [3];
  logic done_v  [3];
  logic terr_v  [3];

  logic        a_rd_en, a_rst_ln, a_begin, a_ack, a_of, a_uf, a_wr_en;
  logic [9:0]  a_rd_addr, a_wr_addr;
  logic [31:0] a_rd_data, a_t, a_result;
  logic [33:0] a_wr_data;

  logic        b_rd_en, b_rst_ln, b_begin, b_ack, b_wr_en;
  logic [9:0]  b_rd_addr, b_wr_addr;
  logic [31:0] b_rd_data, b_t, b_result;
  logic [33:0] b_wr_data;

  logic        c_rd_en, c_rst_ln, c_begin, c_ack, c_wr_en;
  logic [3:0]  c_rd_addr, c_wr_addr;
  logic [31:0] c_rd_data, c_t, c_result;
  logic [33:0] c_wr_data;

  typedef struct packed {
    logic [3:0][7:0] lat;
    logic [3:0][1:0] flg;
    logic            hold;
    logic            pulse;
    logic [15:0]     cyc;
    logic            terr;
  } scen_t;

  typedef struct packed {
    logic [9:0]  addr;
    logic [33:0] data;
  } sb_t;

  scen_t tbl [6];
  scen_t cur;
  sb_t   sb [$];
  int    k;
  bit    run;
  int    m_s;
  int    b_cnt;
  int    c_cnt;

  lin_batch_driver #(.P(32), .AW(10), .N_SAMPLES(4), .TIMEOUT(50)) u_a (
    .CLK(CLK), .RST_N(RST_N), .START(start_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0]),
    .TIMEOUT_ERR(terr_v[0]), .RD_EN(a_rd_en), .RD_ADDR(a_rd_addr), .RD_DATA(a_rd_data),
    .T(a_t), .RST_FSM_LN(a_rst_ln), .BEGIN_FSM_LN(a_begin), .ACK_LN(a_ack), .O_F(a_of),
    .U_F(a_uf), .RESULT(a_result), .WR_EN(a_wr_en), .WR_ADDR(a_wr_addr), .WR_DATA(a_wr_data)
  );

  lin_batch_driver #(.P(32), .AW(10), .N_SAMPLES(1), .TIMEOUT(50)) u_b (
    .CLK(CLK), .RST_N(RST_N), .START(start_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1]),
    .TIMEOUT_ERR(terr_v[1]), .RD_EN(b_rd_en), .RD_ADDR(b_rd_addr), .RD_DATA(b_rd_data),
    .T(b_t), .RST_FSM_LN(b_rst_ln), .BEGIN_FSM_LN(b_begin), .ACK_LN(b_ack), .O_F(1'b0),
    .U_F(1'b0), .RESULT(b_result), .WR_EN(b_wr_en), .WR_ADDR(b_wr_addr), .WR_DATA(b_wr_data)
  );

  lin_batch_driver #(.P(32), .AW(4), .N_SAMPLES(16), .TIMEOUT(50)) u_c (
    .CLK(CLK), .RST_N(RST_N), .START(start_v[2]), .BUSY(busy_v[2]), .DONE(done_v[2]),
    .TIMEOUT_ERR(terr_v[2]), .RD_EN(c_rd_en), .RD_ADDR(c_rd_addr), .RD_DATA(c_rd_data),
    .T(c_t), .RST_FSM_LN(c_rst_ln), .BEGIN_FSM_LN(c_begin), .ACK_LN(c_ack), .O_F(1'b0),
    .U_F(1'b0), .RESULT(c_result), .WR_EN(c_wr_en), .WR_ADDR(c_wr_addr), .WR_DATA(c_wr_data)
  );

  function automatic logic [31:0] rom(input int a);
    case (a)
      0:       rom = 32'h3E9A0000;
      1:       rom = 32'h3F000000;
      2:       rom = 32'h3DCCCCCD;
      3:       rom = 32'h3E19999A;
      default: rom = 32'h40000000 + 32'(a) * 32'h00010203;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Linearizer model and scoreboard for instance A; acks on WAIT cycle lat[sample].
  always @(negedge CLK) begin
    sb_t e;
    if (a_rd_en) a_rd_data = rom(int'(a_rd_addr));
    a_result = ~a_t;
    a_ack = cur.hold;
    a_of  = 1'b0;
    a_uf  = 1'b0;
    if (!RST_N || done_v[0]) begin
      run = 1'b0;
      m_s = 0;
    end else if (a_begin) begin
      k   = 0;
      run = 1'b1;
    end else if (run) begin
      k++;
      if (!cur.hold && m_s < 4 && k == int'(cur.lat[m_s])) begin
        a_ack = 1'b1;
        a_of  = cur.flg[m_s][1];
        a_uf  = cur.flg[m_s][0];
      end
    end
    if (a_wr_en) begin
      run = 1'b0;
      chk("a_sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("a_wr_addr", a_wr_addr, e.addr);
        chk("a_wr_data", a_wr_data, e.data);
      end
      m_s++;
    end
  end

  always @(negedge CLK) begin
    if (b_rd_en) b_rd_data = rom(int'(b_rd_addr));
    if (c_rd_en) c_rd_data = rom(int'(c_rd_addr));
    b_result = ~b_t;
    c_result = ~c_t;
    if (b_wr_en) begin
      chk("n1_addr", b_wr_addr, b_cnt);
      chk("n1_data", b_wr_data, {2'b00, ~rom(b_cnt)});
      chk("n1_rst_ln", b_rst_ln, 0);
      b_cnt++;
    end
    if (c_wr_en) begin
      chk("n16_addr", c_wr_addr, c_cnt);
      chk("n16_data", c_wr_data, {2'b00, ~rom(c_cnt)});
      chk("n16_rst_ln", c_rst_ln, 0);
      c_cnt++;
    end
  end

  task automatic push_exp();
    for (int s = 0; s < 4; s++) begin
      sb_t e;
      e.addr = 10'(s);
      if (cur.hold) e.data = {2'b00, ~rom(s)};
      else if (cur.lat[s] == 8'd0) e.data = {34{1'b1}};
      else e.data = {cur.flg[s], ~rom(s)};
      sb.push_back(e);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ctl"}, {busy_v[0], done_v[0], terr_v[0], a_rd_en, a_begin, a_wr_en, a_rst_ln}, 7'b0000001);
    chk({p, "_addr"}, {a_rd_addr, a_wr_addr}, 0);
    chk({p, "_t"}, a_t, 0);
    chk({p, "_wr_data"}, a_wr_data, 0);
  endtask

  task automatic run_batch(input int inst, input int exp_cyc, input int exp_terr, input string nm);
    int c;
    @(negedge CLK);
    start_v[inst] = 1'b1;
    @(negedge CLK);
    start_v[inst] = 1'b0;
    chk({nm, "_busy_rise"}, busy_v[inst], 1);
    chk({nm, "_terr_clr"}, terr_v[inst], 0);
    c = 0;
    while (!done_v[inst] && c < 3000) begin
      start_v[inst] = (inst == 0 && cur.pulse && (c == 30 || c == 60));
      @(negedge CLK);
      c++;
    end
    start_v[inst] = 1'b0;
    chk({nm, "_cycles"}, c, exp_cyc);
    chk({nm, "_busy_at_done"}, busy_v[inst], 0);
    chk({nm, "_terr"}, terr_v[inst], exp_terr);
    @(negedge CLK);
    chk({nm, "_done_pulse"}, done_v[inst], 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "global timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    k = 0;
    run = 1'b0;
    m_s = 0;
    b_cnt = 0;
    c_cnt = 0;
    RST_N = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    a_ack = 1'b0; a_of = 1'b0; a_uf = 1'b0;
    a_rd_data = '0; b_rd_data = '0; c_rd_data = '0;
    a_result = '0; b_result = '0; c_result = '0;
    b_ack = 1'b1;
    c_ack = 1'b1;

    tbl[0] = '{lat: {8'd20, 8'd20, 8'd20, 8'd20}, flg: 8'h00, hold: 1'b0, pulse: 1'b0, cyc: 16'd104, terr: 1'b0};
    tbl[1] = '{lat: {8'd20, 8'd20, 8'd20, 8'd20}, flg: {2'b00, 2'b01, 2'b10, 2'b00}, hold: 1'b0, pulse: 1'b0, cyc: 16'd104, terr: 1'b0};
    tbl[2] = '{lat: {8'd20, 8'd0, 8'd20, 8'd20}, flg: 8'h00, hold: 1'b0, pulse: 1'b0, cyc: 16'd134, terr: 1'b1};
    tbl[3] = '{lat: {8'd20, 8'd20, 8'd20, 8'd50}, flg: 8'h00, hold: 1'b0, pulse: 1'b0, cyc: 16'd134, terr: 1'b0};
    tbl[4] = '{lat: {8'd20, 8'd20, 8'd20, 8'd20}, flg: 8'h00, hold: 1'b1, pulse: 1'b0, cyc: 16'd28, terr: 1'b0};
    tbl[5] = '{lat: {8'd20, 8'd20, 8'd20, 8'd20}, flg: 8'h00, hold: 1'b0, pulse: 1'b1, cyc: 16'd104, terr: 1'b0};
    cur = tbl[0];

    repeat (2) @(negedge CLK);
    chk_reset("rst");
    RST_N = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cur = tbl[i];
      push_exp();
      run_batch(0, int'(tbl[i].cyc), int'(tbl[i].terr), $sformatf("s%0d", i));
      chk($sformatf("s%0d_sb_drained", i), sb.size(), 0);
    end

    // Abort in the middle of sample 1's WAIT, then restart from address 0.
    cur = tbl[0];
    push_exp();
    @(negedge CLK);
    start_v[0] = 1'b1;
    @(negedge CLK);
    start_v[0] = 1'b0;
    begin
      int n;
      n = 0;
      while (!(m_s == 1 && run && k == 5) && n < 500) begin
        @(negedge CLK);
        n++;
      end
      chk("midrst_reached", (n < 500), 1);
    end
    #1 RST_N = 1'b0;
    #1;
    chk_reset("midrst");
    sb.delete();
    repeat (3) begin
      @(negedge CLK);
      chk("midrst_wr_en", a_wr_en, 0);
      chk("midrst_rst_ln", a_rst_ln, 1);
    end
    RST_N = 1'b1;
    push_exp();
    run_batch(0, 104, 0, "restart");
    chk("restart_sb_drained", sb.size(), 0);

    run_batch(1, 7, 0, "n1");
    chk("n1_writes", b_cnt, 1);
    run_batch(2, 112, 0, "n16");
    chk("n16_writes", c_cnt, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
